// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard tracker: forward-select
// encodings, the "operand unused" tuse marker, the per-stage entry record
// and small helpers used by both the tracker and its operand matcher.
package hazard_pkg;

  // D-stage forward select: register file, E-stage result, M-stage result
  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2
  } dfwd_e;

  // E-stage forward select: pipeline register, M-stage result, W-stage result
  typedef enum logic [1:0] {
    EFWD_REG = 2'd0,
    EFWD_M   = 2'd1,
    EFWD_W   = 2'd2
  } efwd_e;

  // A tuse of 3 marks an operand the instruction never reads
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // One in-flight producer: destination register and cycles until its
  // result exists (waddr 0 means the slot holds a bubble)
  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
  } entry_t;

  localparam entry_t BUBBLE = '{waddr: 5'd0, tnew: 2'd0};

  // One pipeline step closer to the result, never going below zero
  function automatic logic [1:0] decTnew(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

  // E-stage operand source: a ready M result beats W, and register 0 never
  // matches because $0 is hardwired and bubbles carry waddr 0
  function automatic efwd_e eFwdSel(input logic [4:0] consumer,
                                    input entry_t mEntry,
                                    input logic [4:0] wWaddr);
    if (consumer == 5'd0)
      return EFWD_REG;
    if ((consumer == mEntry.waddr) && (mEntry.tnew == 2'd0))
      return EFWD_M;
    if (consumer == wWaddr)
      return EFWD_W;
    return EFWD_REG;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Matches one D-stage source operand against the E and M producers and
// reports whether a producer is relevant, which one decides (the younger
// E entry shadows M), and how far that producer is from having its result.
module hz_match
  import hazard_pkg::*;
(
  input  logic [4:0] i_reg,
  input  logic [1:0] i_tuse,
  input  entry_t     i_eEntry,
  input  entry_t     i_mEntry,
  output logic       o_match,
  output logic       o_fromE,
  output logic [1:0] o_tnew
);

  logic w_used;
  logic w_hitE;
  logic w_hitM;

  // Youngest matching producer wins; unused operands and $0 never match
  always_comb begin
    w_used  = (i_tuse != TUSE_NONE) && (i_reg != 5'd0);
    w_hitE  = w_used && (i_reg == i_eEntry.waddr);
    w_hitM  = w_used && (i_reg == i_mEntry.waddr);
    o_match = w_hitE || w_hitM;
    o_fromE = w_hitE;
    o_tnew  = w_hitE ? i_eEntry.tnew : (w_hitM ? i_mEntry.tnew : 2'd0);
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tuse/tnew hazard tracker for a five-stage pipeline. It shadows the E, M
// and W stages with producer records, decides stalls for the instruction in
// D, and drives the forward selects for D, E and M-stage store data.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_waddr,
  input  logic [1:0] d_tnew,
  output logic [1:0] d_fwd_rs,
  output logic [1:0] d_fwd_rt,
  output logic [1:0] e_fwd_rs,
  output logic [1:0] e_fwd_rt,
  output logic       m_fwd_rt,
  output logic       stall
);

  entry_t     r_eEntry;
  entry_t     r_mEntry;
  entry_t     r_wEntry;
  logic [4:0] r_eRs;
  logic [4:0] r_eRt;
  logic [4:0] r_mRt;

  logic       w_rsMatch;
  logic       w_rsFromE;
  logic [1:0] w_rsTnew;
  logic       w_rtMatch;
  logic       w_rtFromE;
  logic [1:0] w_rtTnew;
  logic       w_rsStall;
  logic       w_rtStall;
  logic       w_stall;

  // W results reach consumers through the register file bypass, so only the
  // W destination matters; its tnew is kept for a uniform entry layout
  logic       w_unusedWTnew;
  assign w_unusedWTnew = ^r_wEntry.tnew;

  hz_match u_rsMatch (
    .i_reg    (d_rs),
    .i_tuse   (d_tuse_rs),
    .i_eEntry (r_eEntry),
    .i_mEntry (r_mEntry),
    .o_match  (w_rsMatch),
    .o_fromE  (w_rsFromE),
    .o_tnew   (w_rsTnew)
  );

  hz_match u_rtMatch (
    .i_reg    (d_rt),
    .i_tuse   (d_tuse_rt),
    .i_eEntry (r_eEntry),
    .i_mEntry (r_mEntry),
    .o_match  (w_rtMatch),
    .o_fromE  (w_rtFromE),
    .o_tnew   (w_rtTnew)
  );

  // Stall when the deciding producer cannot deliver before the operand is
  // needed; reset overrides so the pipeline is never held during reset
  always_comb begin
    w_rsStall = w_rsMatch && (w_rsTnew > d_tuse_rs);
    w_rtStall = w_rtMatch && (w_rtTnew > d_tuse_rt);
    w_stall   = d_valid && !reset && (w_rsStall || w_rtStall);
  end

  // Forward selects are pure functions of the tracked state and D inputs
  always_comb begin
    stall    = w_stall;
    d_fwd_rs = FWD_GRF;
    d_fwd_rt = FWD_GRF;
    if (!w_stall && w_rsMatch && (w_rsTnew == 2'd0))
      d_fwd_rs = w_rsFromE ? FWD_E : FWD_M;
    if (!w_stall && w_rtMatch && (w_rtTnew == 2'd0))
      d_fwd_rt = w_rtFromE ? FWD_E : FWD_M;
    e_fwd_rs = eFwdSel(r_eRs, r_mEntry, r_wEntry.waddr);
    e_fwd_rt = eFwdSel(r_eRt, r_mEntry, r_wEntry.waddr);
    m_fwd_rt = (r_mRt != 5'd0) && (r_mRt == r_wEntry.waddr);
  end

  // Shift producers down the pipe each cycle; a stall or empty D slot
  // injects a bubble into E while older instructions keep draining
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eEntry <= BUBBLE;
      r_mEntry <= BUBBLE;
      r_wEntry <= BUBBLE;
      r_eRs    <= 5'd0;
      r_eRt    <= 5'd0;
      r_mRt    <= 5'd0;
    end else begin
      r_wEntry <= r_mEntry;
      r_mEntry <= '{waddr: r_eEntry.waddr, tnew: decTnew(r_eEntry.tnew)};
      r_mRt    <= r_eRt;
      if (d_valid && !w_stall) begin
        r_eEntry <= '{waddr: d_waddr, tnew: d_tnew};
        r_eRs    <= d_rs;
        r_eRt    <= d_rt;
      end else begin
        r_eEntry <= BUBBLE;
        r_eRs    <= 5'd0;
        r_eRt    <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: each scenario drives one D-stage
// instruction per cycle, queues the hand-derived output vector, and compares
// it against the DUT outputs on the following falling edge.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_waddr;
  logic [1:0] d_tnew;
  logic [1:0] d_fwd_rs;
  logic [1:0] d_fwd_rt;
  logic [1:0] e_fwd_rs;
  logic [1:0] e_fwd_rt;
  logic       m_fwd_rt;
  logic       stall;

  int checks   = 0;
  int failures = 0;

  // Expected output vectors and their labels, in stimulus order
  logic [9:0] expQ[$];
  string      nameQ[$];

  typedef struct {
    bit         rst;
    bit         v;
    logic [4:0] rs;
    logic [1:0] tuseRs;
    logic [4:0] rt;
    logic [1:0] tuseRt;
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic [9:0] exp;
  } row_t;

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  wire [9:0] observed = {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt};

  hazard_tracker dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_waddr   (d_waddr),
    .d_tnew    (d_tnew),
    .d_fwd_rs  (d_fwd_rs),
    .d_fwd_rt  (d_fwd_rt),
    .e_fwd_rs  (e_fwd_rs),
    .e_fwd_rt  (e_fwd_rt),
    .m_fwd_rt  (m_fwd_rt),
    .stall     (stall)
  );

  function automatic logic [9:0] pk(logic st, logic [1:0] dr, logic [1:0] dt,
                                    logic [1:0] er, logic [1:0] et, logic mf);
    return {st, dr, dt, er, et, mf};
  endfunction

  function automatic row_t mkRow(bit rst, bit v, logic [4:0] rs, logic [1:0] tuseRs,
                                 logic [4:0] rt, logic [1:0] tuseRt,
                                 logic [4:0] waddr, logic [1:0] tnew, logic [9:0] exp);
    row_t r;
    r.rst = rst; r.v = v; r.rs = rs; r.tuseRs = tuseRs; r.rt = rt;
    r.tuseRt = tuseRt; r.waddr = waddr; r.tnew = tnew; r.exp = exp;
    return r;
  endfunction

  task automatic applyStimulus(input row_t r, input string name);
    reset     = r.rst;
    d_valid   = r.v;
    d_rs      = r.rs;
    d_tuse_rs = r.tuseRs;
    d_rt      = r.rt;
    d_tuse_rt = r.tuseRt;
    d_waddr   = r.waddr;
    d_tnew    = r.tnew;
    expQ.push_back(r.exp);
    nameQ.push_back(name);
  endtask

  // Drain the pipeline with empty D slots so each scenario starts clean
  task automatic flush();
    reset = 1'b0; d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_waddr = 5'd0; d_tnew = 2'd0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    rows.push_back(mkRow(1, 1, 5'd1, 2'd0, 5'd0, 2'd3, 5'd2, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("reset[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 2'd1, pk(1, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 2'd1, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 2, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("load_use[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_branch();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd1, 2'd1, 5'd2, 2'd1, 5'd5, 2'd1, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd5, 2'd0, 5'd6, 2'd0, 5'd0, 2'd0, pk(1, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd5, 2'd0, 5'd6, 2'd0, 5'd0, 2'd0, pk(0, 2, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("alu_branch[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_e_forward();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd3, 2'd1, 5'd3, 2'd1, 5'd4, 2'd1, pk(0, 1, 1, 0, 0, 0)));
    rows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 1, 1, 0)));
    rows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 1)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("e_forward[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("zero_reg[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_double_write();
    row_t rows[$];
    row_t storeRows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd7, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd7, 2'd0, 5'd0, 2'd3, 5'd9, 2'd1, pk(0, 1, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("double_write[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
    flush();
    storeRows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd7, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    storeRows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    storeRows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    storeRows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 1)));
    foreach (storeRows[i]) begin
      applyStimulus(storeRows[i], $sformatf("store_fwd[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd0, 2'd3, 5'd8, 2'd0, 5'd0, 2'd0, pk(1, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd0, 2'd3, 5'd8, 2'd0, 5'd0, 2'd0, pk(1, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd0, 2'd3, 5'd8, 2'd0, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("back_to_back[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_invalid();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 0, 5'd8, 2'd0, 5'd0, 2'd3, 5'd12, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd12, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, pk(0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("invalid[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t rows[$];
    logic [9:0] expected;
    string name;
    flush();
    rows.push_back(mkRow(0, 1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd10, 2'd1, pk(1, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(1, 1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd10, 2'd1, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd9, 2'd1, pk(0, 0, 0, 0, 0, 0)));
    rows.push_back(mkRow(0, 1, 5'd1, 2'd1, 5'd2, 2'd1, 5'd2, 2'd1, pk(0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      applyStimulus(rows[i], $sformatf("reset_mid_stall[%0d]", i));
      @(negedge clk);
      expected = expQ.pop_front();
      name     = nameQ.pop_front();
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL %s observed=%b expected=%b", name, observed, expected);
      end
      @(posedge clk); #1;
    end
  endtask

  // Runaway guard so the bench always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    reset = 1'b1; d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_waddr = 5'd0; d_tnew = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_e_forward();
    test_zero_reg();
    test_double_write();
    test_back_to_back();
    test_invalid();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
